avst_rr_arbiter: RTL and testbench

AVST_RR_ARBITER -- requirements
Module: avst_rr_arbiter

---
 rtl/avst_rr_arbiter_if.sv | 40 ++++
 rtl/avst_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_avst_rr_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/avst_rr_arbiter_if.sv
// Avalon-ST bundle between NUM_REQ requester sinks, the arbiter and the
// downstream FIFO write port. The arbiter takes the master view; the
// environment (requesters plus FIFO) takes the slave view.
interface avst_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            in_valid;
    logic [NUM_REQ-1:0]            in_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [IDW-1:0]                grant_id;
    logic                          busy;

    modport master (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output grant_id,
        output busy
    );

    modport slave (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  grant_id,
        input  busy
    );
endinterface

// File: rtl/avst_rr_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ Avalon-ST requesters into one
// registered output stream. Each grant carries up to MAX_BURST beats and is
// preceded by a one-cycle arbitration bubble in IDLE.
module avst_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                clk,
    input  logic                aresetn,
    avst_rr_arbiter_if.master   bus
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);
    localparam logic [IDW-1:0] LAST_REQ  = IDW'(NUM_REQ - 1);
    localparam logic [IDW:0]   NUM_REQ_W = (IDW+1)'(NUM_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]        grant_id_q, grant_id_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic [DATA_WIDTH-1:0] slice [NUM_REQ];
    logic [IDW-1:0]        rr_pick;
    logic [IDW-1:0]        rr_after_grant;
    logic                  gnt_valid;
    logic                  gnt_ready;
    logic                  xfer;

    // Unpack the flat requester payload bus and build per-requester ready.
    // Only the granted requester sees ready, and only while the output
    // register is empty or being drained this cycle.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign slice[gi] = bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign bus.in_ready[gi] = (state_q == GRANT) &&
                                      (grant_id_q == IDW'(gi)) && gnt_ready;
        end
    endgenerate

    assign gnt_valid = bus.in_valid[grant_id_q];
    assign gnt_ready = !out_valid_q || bus.out_ready;
    assign xfer      = (state_q == GRANT) && gnt_valid && gnt_ready;

    assign rr_after_grant = (grant_id_q == LAST_REQ) ? '0 : grant_id_q + IDW'(1);

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    // Scanning from the farthest candidate down lets the nearest one win.
    always_comb begin
        logic [IDW:0] cand;
        rr_pick = grant_id_q;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (bus.in_valid[cand[IDW-1:0]]) begin
                rr_pick = cand[IDW-1:0];
            end
        end
    end

    // Next-state logic: arbitration, burst accounting and output register.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            IDLE: begin
                if (|bus.in_valid) begin
                    grant_id_d = rr_pick;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                // A requester going idle ends its grant immediately; a stalled
                // output neither spends budget nor ends the grant.
                if (!gnt_valid || (xfer && beat_cnt_q == LAST_BEAT)) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    rr_ptr_d   = rr_after_grant;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A drain and a new load in the same cycle keep the register full.
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = slice[grant_id_q];
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = (state_q == GRANT);

endmodule

// File: tb/tb_avst_rr_arbiter.sv
// Directed bench for avst_rr_arbiter: a MAX_BURST=4 instance and a
// MAX_BURST=1 instance share stimulus; sel chooses which one is observed.
module tb_avst_rr_arbiter;
    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic [3:0]   in_valid = '0;
    logic [127:0] in_data = '0;
    logic         out_ready = 1'b1;
    logic         sel = 1'b0;

    logic [31:0]  src_base [4];
    int           src_cnt  [4];
    int           src_idx  [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    avst_rr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus_b4 ();
    avst_rr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus_b1 ();

    assign bus_b4.in_valid  = in_valid;
    assign bus_b4.in_data   = in_data;
    assign bus_b4.out_ready = out_ready;
    assign bus_b1.in_valid  = in_valid;
    assign bus_b1.in_data   = in_data;
    assign bus_b1.out_ready = out_ready;

    avst_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut_b4 (
        .clk(clk), .aresetn(aresetn), .bus(bus_b4));
    avst_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(1)) dut_b1 (
        .clk(clk), .aresetn(aresetn), .bus(bus_b1));

    logic [3:0]  obs_ready;
    logic        obs_busy;
    logic [1:0]  obs_gid;
    logic        obs_ov;
    logic [31:0] obs_od;
    assign obs_ready = sel ? bus_b1.in_ready  : bus_b4.in_ready;
    assign obs_busy  = sel ? bus_b1.busy      : bus_b4.busy;
    assign obs_gid   = sel ? bus_b1.grant_id  : bus_b4.grant_id;
    assign obs_ov    = sel ? bus_b1.out_valid : bus_b4.out_valid;
    assign obs_od    = sel ? bus_b1.out_data  : bus_b4.out_data;

    task automatic check_value(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One line per cycle/transaction, then compare against hand values.
    task automatic chk_cycle(string tag, logic b, logic [1:0] g, logic ov, logic [31:0] od);
        $display("[%0t] %s busy=%0d gid=%0d out_valid=%0d out_data=0x%0h",
                 $time, tag, obs_busy, obs_gid, obs_ov, obs_od);
        check_value({tag, ".busy"}, 32'(obs_busy), 32'(b));
        check_value({tag, ".gid"},  32'(obs_gid),  32'(g));
        check_value({tag, ".ov"},   32'(obs_ov),   32'(ov));
        if (ov) check_value({tag, ".od"}, obs_od, od);
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = (src_cnt[i] != 0);
            in_data[i*32 +: 32] = src_base[i] + 32'(src_idx[i]);
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            src_base[i] = '0;
            src_cnt[i]  = 0;
            src_idx[i]  = 0;
        end
    endtask

    task automatic set_src(int i, logic [31:0] base, int cnt);
        src_base[i] = base;
        src_cnt[i]  = cnt;
        src_idx[i]  = 0;
    endtask

    // One clock: requesters advance on every handshake seen at the edge.
    task automatic step();
        logic [3:0] fire;
        fire = obs_ready & in_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (fire[i]) begin
                src_idx[i]++;
                src_cnt[i]--;
            end
        end
        drive();
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_src();
        drive();
        step();
        step();
        aresetn = 1'b1;
        chk_cycle("reset", 1'b0, 2'd0, 1'b0, 32'h0);
        check_value("reset.in_ready", 32'(obs_ready), 32'h0);
    endtask

    initial begin
        int p, b, r;
        clear_src();
        drive();

        // Single requester, six beats: burst of 4, bubble, then the last 2.
        sel = 1'b0;
        out_ready = 1'b1;
        do_reset();
        set_src(0, 32'hA0, 6);
        drive();
        #1;
        step(); chk_cycle("t1.c1", 1'b1, 2'd0, 1'b0, 32'h0);
        step(); chk_cycle("t1.c2", 1'b1, 2'd0, 1'b1, 32'hA0);
        step(); chk_cycle("t1.c3", 1'b1, 2'd0, 1'b1, 32'hA1);
        step(); chk_cycle("t1.c4", 1'b1, 2'd0, 1'b1, 32'hA2);
        step(); chk_cycle("t1.c5", 1'b0, 2'd0, 1'b1, 32'hA3);
        step(); chk_cycle("t1.c6", 1'b1, 2'd0, 1'b0, 32'h0);
        step(); chk_cycle("t1.c7", 1'b1, 2'd0, 1'b1, 32'hA4);
        step(); chk_cycle("t1.c8", 1'b1, 2'd0, 1'b1, 32'hA5);
        step(); chk_cycle("t1.c9", 1'b0, 2'd0, 1'b0, 32'h0);

        // All four continuously valid: bursts of 4 in order 0,1,2,3,0 with
        // a bubble cycle before each burst (period 5).
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, 32'((i + 1) << 8), 100);
        drive();
        #1;
        for (int n = 1; n <= 22; n++) begin
            step();
            p = (n - 1) % 5;
            b = (n - 1) / 5;
            r = b % 4;
            chk_cycle($sformatf("t2.c%0d", n), p != 4, 2'(r), p != 0,
                      32'((r + 1) << 8) + 32'(4 * (b / 4) + p - 1));
        end

        // Output stall of 10 cycles after first beat of requester 2.
        do_reset();
        set_src(2, 32'hC0, 4);
        drive();
        #1;
        step(); chk_cycle("t3.c1", 1'b1, 2'd2, 1'b0, 32'h0);
        step(); chk_cycle("t3.c2", 1'b1, 2'd2, 1'b1, 32'hC0);
        out_ready = 1'b0;
        #1;
        check_value("t3.stall_ready", 32'(obs_ready), 32'h0);
        for (int n = 3; n <= 12; n++) begin
            step();
            chk_cycle($sformatf("t3.c%0d", n), 1'b1, 2'd2, 1'b1, 32'hC0);
            check_value($sformatf("t3.c%0d.in_ready", n), 32'(obs_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check_value("t3.resume_ready", 32'(obs_ready), 32'h4);
        step(); chk_cycle("t3.c13", 1'b1, 2'd2, 1'b1, 32'hC1);
        step(); chk_cycle("t3.c14", 1'b1, 2'd2, 1'b1, 32'hC2);
        step(); chk_cycle("t3.c15", 1'b0, 2'd2, 1'b1, 32'hC3);
        step(); chk_cycle("t3.c16", 1'b0, 2'd2, 1'b0, 32'h0);

        // Requester 1 goes idle after 2 beats; pointer moves to 2, so with
        // requesters 1 and 3 pending, 3 wins, then 1.
        do_reset();
        set_src(1, 32'hD0, 2);
        drive();
        #1;
        step(); chk_cycle("t4.c1", 1'b1, 2'd1, 1'b0, 32'h0);
        step(); chk_cycle("t4.c2", 1'b1, 2'd1, 1'b1, 32'hD0);
        step(); chk_cycle("t4.c3", 1'b1, 2'd1, 1'b1, 32'hD1);
        step(); chk_cycle("t4.c4", 1'b0, 2'd1, 1'b0, 32'h0);
        set_src(1, 32'hD8, 2);
        set_src(3, 32'hE0, 2);
        drive();
        #1;
        step(); chk_cycle("t4.c5", 1'b1, 2'd3, 1'b0, 32'h0);
        step(); chk_cycle("t4.c6", 1'b1, 2'd3, 1'b1, 32'hE0);
        step(); chk_cycle("t4.c7", 1'b1, 2'd3, 1'b1, 32'hE1);
        step(); chk_cycle("t4.c8", 1'b0, 2'd3, 1'b0, 32'h0);
        step(); chk_cycle("t4.c9", 1'b1, 2'd1, 1'b0, 32'h0);
        step(); chk_cycle("t4.c10", 1'b1, 2'd1, 1'b1, 32'hD8);

        // MAX_BURST=1 instance: one beat per grant, rotating every grant.
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, 32'((i + 1) << 8), 100);
        drive();
        #1;
        for (int n = 1; n <= 10; n++) begin
            step();
            b = (n - 1) / 2;
            r = b % 4;
            if (n % 2 == 1)
                chk_cycle($sformatf("t5.c%0d", n), 1'b1, 2'(r), 1'b0, 32'h0);
            else
                chk_cycle($sformatf("t5.c%0d", n), 1'b0, 2'(r), 1'b1,
                          32'((r + 1) << 8) + 32'(b / 4));
        end

        // Reset in mid-burst drops the held beat and restarts at requester 0.
        sel = 1'b0;
        do_reset();
        set_src(1, 32'hF0, 4);
        drive();
        #1;
        step(); chk_cycle("t6.c1", 1'b1, 2'd1, 1'b0, 32'h0);
        step(); chk_cycle("t6.c2", 1'b1, 2'd1, 1'b1, 32'hF0);
        aresetn = 1'b0;
        step(); chk_cycle("t6.c3", 1'b0, 2'd0, 1'b0, 32'h0);
        check_value("t6.c3.in_ready", 32'(obs_ready), 32'h0);
        aresetn = 1'b1;
        clear_src();
        set_src(0, 32'h50, 2);
        set_src(3, 32'h60, 2);
        drive();
        #1;
        step(); chk_cycle("t6.c4", 1'b1, 2'd0, 1'b0, 32'h0);
        step(); chk_cycle("t6.c5", 1'b1, 2'd0, 1'b1, 32'h50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
